// File: rtl/instr_fetch_unit_pkg.sv
// Shared widths and the fetch buffer payload type for the instruction fetch unit.
package instr_fetch_unit_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned PC_STEP = 4;
    localparam int unsigned CNT_W   = 2;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory, redirect and decode-handshake signals of the fetch unit.
interface instr_fetch_unit_if;

    logic [instr_fetch_unit_pkg::ADDR_W-1:0]  imem_address;
    logic [instr_fetch_unit_pkg::INSTR_W-1:0] imem_instruction;
    logic                                     redirect;
    logic [instr_fetch_unit_pkg::ADDR_W-1:0]  redirect_pc;
    logic                                     out_valid;
    logic                                     out_ready;
    logic [instr_fetch_unit_pkg::INSTR_W-1:0] out_instruction;
    logic [instr_fetch_unit_pkg::ADDR_W-1:0]  out_pc;
    logic                                     fault;

    modport master (
        output imem_address,
        input  imem_instruction,
        input  redirect,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instruction,
        output out_pc,
        output fault
    );

    modport slave (
        input  imem_address,
        output imem_instruction,
        output redirect,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instruction,
        input  out_pc,
        input  fault
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Two-entry in-order fetch buffer; slot0 is always the head so outputs come straight from flops.
module instr_fetch_unit_fetch_buffer
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     push_data,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             valid
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    fetch_entry_t     slot0_q, slot0_d;
    fetch_entry_t     slot1_q, slot1_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             pop_eff;
    logic             push_eff;

    // Pop shifts slot1 into the head; a push lands in the first free slot after the pop.
    always_comb begin
        slot0_d  = slot0_q;
        slot1_d  = slot1_q;
        count_d  = count_q;
        pop_eff  = pop & valid_q;
        push_eff = push & ((count_q != FULL) | pop_eff);
        if (flush) begin
            count_d = '0;
        end else begin
            case ({push_eff, pop_eff})
                2'b11: begin
                    if (count_q == CNT_W'(1)) begin
                        slot0_d = push_data;
                    end else begin
                        slot0_d = slot1_q;
                        slot1_d = push_data;
                    end
                end
                2'b01: begin
                    slot0_d = slot1_q;
                    count_d = count_q - CNT_W'(1);
                end
                2'b10: begin
                    if (count_q == '0) begin
                        slot0_d = push_data;
                    end else begin
                        slot1_d = push_data;
                    end
                    count_d = count_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign head  = slot0_q;
    assign count = count_q;
    assign valid = valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: owns the PC, reads the combinational instruction ROM and feeds decode through a 2-entry buffer.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] SIZE      = 32'h0000_000c,
    parameter int unsigned       BUF_DEPTH = 2
) (
    input  logic                clock,
    input  logic                reset,
    instr_fetch_unit_if.master  bus
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;
    logic              pop;
    logic              push;
    logic              flush;
    logic              in_range;
    logic              fetch_ok;
    fetch_entry_t      push_data;
    fetch_entry_t      head;
    logic [CNT_W-1:0]  count;
    logic              buf_valid;

    // Redirect wins over fetch and pop; an out-of-range PC raises a sticky fault instead of fetching.
    always_comb begin
        pc_d      = pc_q;
        fault_d   = fault_q;
        push      = 1'b0;
        flush     = 1'b0;
        push_data = '{pc: pc_q, instr: bus.imem_instruction};
        pop       = buf_valid & bus.out_ready;
        in_range  = (pc_q < SIZE);
        fetch_ok  = !fault_q & in_range & ((count != FULL) | pop);
        if (bus.redirect) begin
            flush   = 1'b1;
            pc_d    = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            fault_d = (bus.redirect_pc[1:0] != 2'b00) | (bus.redirect_pc >= SIZE);
        end else if (fetch_ok) begin
            push = 1'b1;
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end else if (!in_range) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q    <= {RESET_PC[ADDR_W-1:2], 2'b00};
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    instr_fetch_unit_fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data (push_data),
        .head      (head),
        .count     (count),
        .valid     (buf_valid)
    );

    assign bus.imem_address    = pc_q;
    assign bus.out_valid       = buf_valid;
    assign bus.out_instruction = head.instr;
    assign bus.out_pc          = head.pc;
    assign bus.fault           = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios push expected (pc, instr) pairs, a monitor checks them.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic clock;
    logic reset;

    instr_fetch_unit_if ifc();

    instr_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .SIZE      (32'h0000_000c),
        .BUF_DEPTH (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    int n_checks = 0;
    int n_fail   = 0;
    fetch_entry_t exp_q[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Three-word instruction ROM.
    always_comb begin
        case (ifc.imem_address)
            32'h0:   ifc.imem_instruction = 32'h0000_000A;
            32'h4:   ifc.imem_instruction = 32'h0000_000B;
            32'h8:   ifc.imem_instruction = 32'h0000_000C;
            default: ifc.imem_instruction = 32'hDEAD_BEEF;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic expect_abc();
        exp_q.push_back('{pc: 32'h0, instr: 32'hA});
        exp_q.push_back('{pc: 32'h4, instr: 32'hB});
        exp_q.push_back('{pc: 32'h8, instr: 32'hC});
    endtask

    task automatic do_redirect(input logic [31:0] target, input logic ready);
        ifc.redirect    = 1'b1;
        ifc.redirect_pc = target;
        ifc.out_ready   = ready;
        exp_q.delete();
    endtask

    // Monitor: every accepted head (not cancelled by a redirect) must match the scoreboard front.
    always @(negedge clock) begin
        if (!reset && ifc.out_valid && ifc.out_ready && !ifc.redirect) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got pc %h instr %h expected none", ifc.out_pc, ifc.out_instruction);
            end else begin
                fetch_entry_t e;
                e = exp_q.pop_front();
                chk("out_pc", ifc.out_pc, e.pc);
                chk("out_instruction", ifc.out_instruction, e.instr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        ifc.redirect    = 1'b0;
        ifc.redirect_pc = 32'h0;
        ifc.out_ready   = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        chk("rst_out_valid", 32'(ifc.out_valid), 32'h0);
        chk("rst_out_pc", ifc.out_pc, 32'h0);
        chk("rst_out_instr", ifc.out_instruction, 32'h0);
        chk("rst_fault", 32'(ifc.fault), 32'h0);
        chk("rst_addr", ifc.imem_address, 32'h0);

        // Streaming from reset into the end of the ROM.
        reset = 1'b0;
        expect_abc();
        chk("seq_addr0", ifc.imem_address, 32'h0);
        tick(); chk("seq_addr1", ifc.imem_address, 32'h4);
        chk("seq_valid1", 32'(ifc.out_valid), 32'h1);
        tick(); chk("seq_addr2", ifc.imem_address, 32'h8);
        tick(); chk("seq_addr3", ifc.imem_address, 32'hC);
        chk("seq_valid3", 32'(ifc.out_valid), 32'h1);
        chk("seq_fault3", 32'(ifc.fault), 32'h0);
        tick(); chk("seq_fault4", 32'(ifc.fault), 32'h1);
        chk("seq_valid4", 32'(ifc.out_valid), 32'h0);
        chk("seq_addr4", ifc.imem_address, 32'hC);
        tick(); chk("seq_valid5", 32'(ifc.out_valid), 32'h0);

        // Backpressure: fill the buffer, then drain.
        do_redirect(32'h0, 1'b0);
        expect_abc();
        tick(); ifc.redirect = 1'b0;
        chk("bp_fault_cleared", 32'(ifc.fault), 32'h0);
        chk("bp_valid_r1", 32'(ifc.out_valid), 32'h0);
        chk("bp_addr_r1", ifc.imem_address, 32'h0);
        tick(); chk("bp_addr_r2", ifc.imem_address, 32'h4);
        tick(); chk("bp_addr_r3", ifc.imem_address, 32'h8);
        tick(); chk("bp_addr_r4", ifc.imem_address, 32'h8);
        chk("bp_valid_r4", 32'(ifc.out_valid), 32'h1);
        chk("bp_head_pc_r4", ifc.out_pc, 32'h0);
        tick(); chk("bp_addr_r5", ifc.imem_address, 32'h8);
        ifc.out_ready = 1'b1;
        tick(); chk("bp_addr_r6", ifc.imem_address, 32'hC);
        tick(); chk("bp_fault_r7", 32'(ifc.fault), 32'h1);
        chk("bp_valid_r7", 32'(ifc.out_valid), 32'h1);
        tick(); chk("bp_valid_r8", 32'(ifc.out_valid), 32'h0);
        chk("bp_left", 32'(exp_q.size()), 32'h0);

        // Redirect while two entries are buffered and decode is ready.
        do_redirect(32'h0, 1'b0);
        tick(); ifc.redirect = 1'b0;
        tick();
        tick(); chk("rd_valid_full", 32'(ifc.out_valid), 32'h1);
        chk("rd_addr_full", ifc.imem_address, 32'h8);
        do_redirect(32'h4, 1'b1);
        exp_q.push_back('{pc: 32'h4, instr: 32'hB});
        exp_q.push_back('{pc: 32'h8, instr: 32'hC});
        tick(); ifc.redirect = 1'b0;
        chk("rd_valid_after", 32'(ifc.out_valid), 32'h0);
        chk("rd_fault", 32'(ifc.fault), 32'h0);
        chk("rd_addr", ifc.imem_address, 32'h4);
        tick(); chk("rd_valid_2", 32'(ifc.out_valid), 32'h1);
        chk("rd_head_pc_2", ifc.out_pc, 32'h4);
        tick(); tick(); tick();
        chk("rd_left", 32'(exp_q.size()), 32'h0);

        // Misaligned redirect faults and stops fetching; a legal redirect recovers.
        do_redirect(32'h6, 1'b1);
        tick(); ifc.redirect = 1'b0;
        chk("mis_addr", ifc.imem_address, 32'h4);
        chk("mis_fault", 32'(ifc.fault), 32'h1);
        chk("mis_valid", 32'(ifc.out_valid), 32'h0);
        tick(); tick();
        chk("mis_addr_hold", ifc.imem_address, 32'h4);
        chk("mis_valid_hold", 32'(ifc.out_valid), 32'h0);
        do_redirect(32'h0, 1'b1);
        expect_abc();
        tick(); ifc.redirect = 1'b0;
        chk("rec_fault", 32'(ifc.fault), 32'h0);
        chk("rec_addr", ifc.imem_address, 32'h0);
        tick(); chk("rec_valid", 32'(ifc.out_valid), 32'h1);
        tick(); tick(); tick();
        chk("rec_left", 32'(exp_q.size()), 32'h0);

        // Asynchronous reset between edges with two entries buffered.
        do_redirect(32'h0, 1'b0);
        tick(); ifc.redirect = 1'b0;
        tick();
        tick(); chk("mr_valid_before", 32'(ifc.out_valid), 32'h1);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("mr_valid_now", 32'(ifc.out_valid), 32'h0);
        chk("mr_addr_now", ifc.imem_address, 32'h0);
        chk("mr_out_pc_now", ifc.out_pc, 32'h0);
        tick();
        reset = 1'b0;
        ifc.out_ready = 1'b1;
        expect_abc();
        chk("mr_valid_rel", 32'(ifc.out_valid), 32'h0);
        tick(); chk("mr_valid_1", 32'(ifc.out_valid), 32'h1);
        chk("mr_head_pc_1", ifc.out_pc, 32'h0);
        chk("mr_head_instr_1", ifc.out_instruction, 32'hA);
        tick(); tick(); tick();
        chk("mr_left", 32'(exp_q.size()), 32'h0);
        chk("mr_fault_end", 32'(ifc.fault), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
